// File: rtl/rcp_arbiter_if.sv
// Requester-side bus of the rcp arbiter: operand requests, grants and routed results.
// Operand k of the packed req_a bus is slice [k*width +: width].
interface rcp_arbiter_if #(
  parameter int unsigned width = 16,
  parameter int unsigned n_req = 4
);
  logic [n_req-1:0]       req_v;
  logic [n_req*width-1:0] req_a;
  logic [n_req-1:0]       req_gnt;
  logic [n_req-1:0]       resp_v;
  logic [width-1:0]       resp_r;

  // Requester side drives operands and receives grants/results.
  modport master (
    output req_v, req_a,
    input  req_gnt, resp_v, resp_r
  );

  // Arbiter side.
  modport slave (
    input  req_v, req_a,
    output req_gnt, resp_v, resp_r
  );
endinterface

// File: rtl/rcp_arbiter.sv
// Round-robin arbiter sharing one rcp reciprocal unit between n_req requesters.
// Tags each issue, routes results back to their owner, and patches the a == 0 case.
module rcp_arbiter #(
  parameter int unsigned width = 16,
  parameter int unsigned n_req = 4,
  parameter int unsigned lat   = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  rcp_arbiter_if.slave     bus,
  output logic             rcp_v_o,
  output logic [width-1:0] rcp_a_o,
  input  logic [width-1:0] rcp_r_i,
  input  logic             rcp_ready_i,
  output logic             err_o
);
  localparam int unsigned IDX_W  = $clog2(n_req);
  localparam int unsigned HOLD_W = $clog2(lat + 1);

  typedef struct packed {
    logic             v;
    logic [IDX_W-1:0] idx;
    logic             z;
  } tag_t;

  logic [IDX_W-1:0]  ptr_q;
  logic [HOLD_W-1:0] hold_q;
  tag_t              pipe_q [lat];
  tag_t              tag_in;
  tag_t              tag_out;
  logic [width-1:0]  req_a_arr [n_req];
  logic              gnt_found;
  logic [IDX_W-1:0]  gnt_idx;
  logic [width-1:0]  sel_a;
  logic              op_zero;

  for (genvar g = 0; g < n_req; g++) begin : g_unpack
    assign req_a_arr[g] = bus.req_a[g*width +: width];
  end

  // First pending requester at or after p, wrapping; MSB flags a hit.
  function automatic logic [IDX_W:0] pick(input logic [n_req-1:0] v,
                                          input logic [IDX_W-1:0] p);
    logic [IDX_W-1:0] k;
    pick = '0;
    for (int unsigned i = 0; i < n_req; i++) begin
      k = IDX_W'((32'(p) + i) % n_req);
      if (!pick[IDX_W] && v[k]) pick = {1'b1, k};
    end
  endfunction

  always_comb begin
    {gnt_found, gnt_idx} = rst_i ? '0 : pick(bus.req_v, ptr_q);
    bus.req_gnt = '0;
    if (gnt_found) bus.req_gnt[gnt_idx] = 1'b1;
  end

  // Issue path: a zero operand is replaced by 1 so rcp only sees defined inputs.
  always_comb begin
    sel_a   = req_a_arr[gnt_idx];
    op_zero = (sel_a == '0);
    rcp_v_o = gnt_found;
    rcp_a_o = !gnt_found ? '0 : (op_zero ? width'(1) : sel_a);
    tag_in  = '{v: gnt_found, idx: gnt_idx, z: gnt_found & op_zero};
    tag_out = pipe_q[lat-1];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q      <= '0;
      hold_q     <= HOLD_W'(lat);
      err_o      <= 1'b0;
      bus.resp_v <= '0;
      bus.resp_r <= '0;
      for (int unsigned i = 0; i < lat; i++) pipe_q[i] <= '0;
    end else begin
      if (gnt_found)
        ptr_q <= (gnt_idx == IDX_W'(n_req - 1)) ? '0 : IDX_W'(gnt_idx + 1'b1);
      pipe_q[0] <= tag_in;
      for (int unsigned i = 1; i < lat; i++) pipe_q[i] <= pipe_q[i-1];
      bus.resp_v <= '0;
      if (tag_out.v) bus.resp_v[tag_out.idx] <= 1'b1;
      bus.resp_r <= tag_out.z ? '1 : rcp_r_i;
      // Ignore rcp_ready_i until the pipe has refilled after reset.
      if (hold_q != '0) hold_q <= hold_q - 1'b1;
      else if (rcp_ready_i != tag_out.v) err_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_rcp_arbiter.sv
// Directed bench for rcp_arbiter (width=16, n_req=4, lat=1) with a behavioural
// one-cycle rcp computing 0xFFFF / a; expected values are hand-computed.
module tb_rcp_arbiter;
  localparam int unsigned W = 16;
  localparam int unsigned N = 4;
  localparam int unsigned L = 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         rcp_v;
  logic [W-1:0] rcp_a;
  logic [W-1:0] rcp_r_q;
  logic         ready_q;
  logic         force_ready;
  logic         rcp_ready;
  logic         err;
  int           n_vec  = 0;
  int           n_miss = 0;

  rcp_arbiter_if #(.width(W), .n_req(N)) bus ();

  rcp_arbiter #(.width(W), .n_req(N), .lat(L)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .bus         (bus),
    .rcp_v_o     (rcp_v),
    .rcp_a_o     (rcp_a),
    .rcp_r_i     (rcp_r_q),
    .rcp_ready_i (rcp_ready),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  // Behavioural rcp, latency 1.
  always_ff @(posedge clk) begin
    ready_q <= rcp_v;
    rcp_r_q <= (rcp_a == '0) ? 16'hFFFF : 16'(32'hFFFF / 32'(rcp_a));
  end
  assign rcp_ready = ready_q | force_ready;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input int k, input logic [W-1:0] a);
    bus.req_a[k*W +: W] = a;
  endtask

  logic [15:0] a_tab [4];
  logic [15:0] r_tab [4];

  initial begin
    a_tab = '{16'd2, 16'd3, 16'd4, 16'd5};
    r_tab = '{16'h7FFF, 16'h5555, 16'h3FFF, 16'h3333};
    rst = 1'b1;
    force_ready = 1'b0;
    bus.req_v = '0;
    bus.req_a = '0;

    // Reset: grants suppressed, registered outputs cleared.
    tick(); bus.req_v = '1; @(negedge clk);
    check("rst_gnt", 32'(bus.req_gnt), 0);
    check("rst_rcp_v", 32'(rcp_v), 0);
    tick(); bus.req_v = '0; @(negedge clk);
    check("rst_resp_v", 32'(bus.resp_v), 0);
    check("rst_resp_r", 32'(bus.resp_r), 0);
    check("rst_err", 32'(err), 0);
    tick(); rst = 1'b0;

    // All four requesting for 8 cycles: rotate 0..3, results two cycles later.
    for (int k = 0; k < 4; k++) set_a(k, a_tab[k]);
    for (int i = 0; i < 10; i++) begin
      tick(); bus.req_v = (i < 8) ? 4'hF : 4'h0; @(negedge clk);
      check("rr_gnt", 32'(bus.req_gnt), (i < 8) ? (1 << (i % 4)) : 0);
      check("rr_rcp_a", 32'(rcp_a), (i < 8) ? 32'(a_tab[i % 4]) : 0);
      check("rr_resp_v", 32'(bus.resp_v), (i >= 2) ? (1 << ((i - 2) % 4)) : 0);
      if (i >= 2) check("rr_resp_r", 32'(bus.resp_r), 32'(r_tab[(i - 2) % 4]));
    end
    check("rr_err", 32'(err), 0);

    // Lone requester 2, a=4; afterwards ptr=3 so 3 beats 0.
    tick(); bus.req_v = 4'b0100; set_a(2, 16'd4); @(negedge clk);
    check("t1_gnt", 32'(bus.req_gnt), 32'b0100);
    check("t1_rcp_v", 32'(rcp_v), 1);
    check("t1_rcp_a", 32'(rcp_a), 4);
    tick(); bus.req_v = 4'b0000; @(negedge clk);
    check("t1_resp_early", 32'(bus.resp_v), 0);
    tick(); bus.req_v = 4'b1001; set_a(0, 16'd10); set_a(3, 16'd3); @(negedge clk);
    check("t1_resp_v", 32'(bus.resp_v), 32'b0100);
    check("t1_resp_r", 32'(bus.resp_r), 32'h3FFF);
    check("t4_gnt3", 32'(bus.req_gnt), 32'b1000);
    check("t4_rcp_a3", 32'(rcp_a), 3);
    tick(); bus.req_v = 4'b0001; @(negedge clk);
    check("t4_gnt0", 32'(bus.req_gnt), 32'b0001);
    check("t4_rcp_a0", 32'(rcp_a), 10);
    tick(); bus.req_v = 4'b0000; @(negedge clk);
    check("t4_resp3_v", 32'(bus.resp_v), 32'b1000);
    check("t4_resp3_r", 32'(bus.resp_r), 32'h5555);
    tick(); @(negedge clk);
    check("t4_resp0_v", 32'(bus.resp_v), 32'b0001);
    check("t4_resp0_r", 32'(bus.resp_r), 32'h1999);

    // Zero operand from requester 1 (ptr=1), then 0 and 2 contend with ptr=2.
    tick(); bus.req_v = 4'b0010; set_a(1, 16'd0); @(negedge clk);
    check("t3_gnt", 32'(bus.req_gnt), 32'b0010);
    check("t3_rcp_a", 32'(rcp_a), 1);
    tick(); bus.req_v = 4'b0101; @(negedge clk);
    check("t3_gnt2", 32'(bus.req_gnt), 32'b0100);
    tick(); bus.req_v = 4'b0001; @(negedge clk);
    check("t3_gnt0", 32'(bus.req_gnt), 32'b0001);
    check("t3_resp_v", 32'(bus.resp_v), 32'b0010);
    check("t3_resp_r", 32'(bus.resp_r), 32'hFFFF);
    tick(); bus.req_v = 4'b0000; @(negedge clk);
    check("t3_resp2_v", 32'(bus.resp_v), 32'b0100);
    check("t3_resp2_r", 32'(bus.resp_r), 32'h3FFF);
    tick(); @(negedge clk);
    check("t3_resp0_v", 32'(bus.resp_v), 32'b0001);
    check("t3_resp0_r", 32'(bus.resp_r), 32'h1999);
    check("t3_err", 32'(err), 0);

    // Reset one cycle after a grant: its result is dropped, no error, ptr back to 0.
    tick(); bus.req_v = 4'b0010; set_a(1, 16'd7); @(negedge clk);
    check("t5_gnt", 32'(bus.req_gnt), 32'b0010);
    tick(); rst = 1'b1; bus.req_v = 4'b0000; @(negedge clk);
    check("t5_gnt_rst", 32'(bus.req_gnt), 0);
    tick(); rst = 1'b0; @(negedge clk);
    check("t5_resp_v0", 32'(bus.resp_v), 0);
    check("t5_err0", 32'(err), 0);
    tick(); bus.req_v = 4'b1010; @(negedge clk);
    check("t5_resp_v1", 32'(bus.resp_v), 0);
    check("t5_ptr0_gnt", 32'(bus.req_gnt), 32'b0010);
    tick(); bus.req_v = 4'b1000; @(negedge clk);
    check("t5_gnt3", 32'(bus.req_gnt), 32'b1000);
    tick(); bus.req_v = 4'b0000; @(negedge clk);
    check("t5_resp1_v", 32'(bus.resp_v), 32'b0010);
    check("t5_resp1_r", 32'(bus.resp_r), 32'h2492);
    tick(); @(negedge clk);
    check("t5_resp3_v", 32'(bus.resp_v), 32'b1000);
    check("t5_resp3_r", 32'(bus.resp_r), 32'h5555);
    check("t5_err", 32'(err), 0);

    // Spurious rcp_ready_i with nothing in flight: sticky error until reset.
    tick(); force_ready = 1'b1; @(negedge clk);
    check("t6_err_pre", 32'(err), 0);
    tick(); force_ready = 1'b0; @(negedge clk);
    check("t6_err_set", 32'(err), 1);
    tick(); tick(); @(negedge clk);
    check("t6_err_sticky", 32'(err), 1);
    tick(); rst = 1'b1; @(negedge clk);
    tick(); rst = 1'b0; @(negedge clk);
    check("t6_err_clr", 32'(err), 0);
    tick(); tick(); @(negedge clk);
    check("t6_err_quiet", 32'(err), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
